// File: rtl/btb_2way_assoc.sv
// 2-way set-associative branch target buffer with per-set LRU replacement.
// Lookup is registered with one cycle of latency. The update port commits at the clock edge.
// A flush pulse invalidates the array by sweeping it one set per cycle.
// Optional feature macro: BTB_BHT_EN adds a 2-bit saturating direction counter per entry.
module btb_2way_assoc #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned PC_WIDTH     = 10,
  parameter int unsigned OFFSET_WIDTH = 2,
  parameter int unsigned INDEX_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  output logic                  busy,
  input  logic                  lookup_valid,
  input  logic [PC_WIDTH-1:0]   lookup_pc,
  output logic                  pred_valid,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  upd_valid,
  input  logic [PC_WIDTH-1:0]   upd_pc,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target
);
  localparam int unsigned TAG_WIDTH = PC_WIDTH - OFFSET_WIDTH - INDEX_WIDTH;
  localparam int unsigned NUM_SETS  = 2 ** INDEX_WIDTH;
  localparam logic [0:0]  IDLE      = 1'b0;
  localparam logic [0:0]  FLUSH     = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;

  logic                   valid_q [2][NUM_SETS];
  logic [TAG_WIDTH-1:0]   tag_q   [2][NUM_SETS];
  logic [ADDR_WIDTH-1:0]  tgt_q   [2][NUM_SETS];
  logic [NUM_SETS-1:0]    lru_q;
`ifdef BTB_BHT_EN
  logic [1:0]             ctr_q   [2][NUM_SETS];
  logic [1:0]             ctr_nxt;
`endif

  logic [TAG_WIDTH-1:0]   lk_tag, up_tag;
  logic [INDEX_WIDTH-1:0] lk_idx, up_idx;
  logic                   lk_m0, lk_m1, lk_hit, lk_way, lk_taken;
  logic                   up_m0, up_m1, up_hit, up_way, up_en, victim;
  logic                   unused_pc_bits;

  assign unused_pc_bits = ^{lookup_pc[OFFSET_WIDTH-1:0], upd_pc[OFFSET_WIDTH-1:0]};
  assign busy = (state_q == FLUSH);

  // Field split and tag compare for the lookup and update ports; way0 wins a double match.
  always_comb begin
    lk_tag = lookup_pc[PC_WIDTH-1 -: TAG_WIDTH];
    lk_idx = lookup_pc[OFFSET_WIDTH +: INDEX_WIDTH];
    up_tag = upd_pc[PC_WIDTH-1 -: TAG_WIDTH];
    up_idx = upd_pc[OFFSET_WIDTH +: INDEX_WIDTH];
    lk_m0  = valid_q[0][lk_idx] && (tag_q[0][lk_idx] == lk_tag);
    lk_m1  = valid_q[1][lk_idx] && (tag_q[1][lk_idx] == lk_tag);
    lk_hit = lookup_valid && (lk_m0 || lk_m1) && (state_q == IDLE);
    lk_way = !lk_m0;
    up_m0  = valid_q[0][up_idx] && (tag_q[0][up_idx] == up_tag);
    up_m1  = valid_q[1][up_idx] && (tag_q[1][up_idx] == up_tag);
    up_hit = up_m0 || up_m1;
    up_way = !up_m0;
    up_en  = upd_valid && !flush && (state_q == IDLE);
    victim = !valid_q[0][up_idx] ? 1'b0 : (!valid_q[1][up_idx] ? 1'b1 : lru_q[up_idx]);
`ifdef BTB_BHT_EN
    lk_taken = ctr_q[lk_way][lk_idx][1];
    ctr_nxt  = ctr_q[up_way][up_idx];
    if (upd_taken && (ctr_nxt != 2'd3))
      ctr_nxt = 2'(ctr_nxt + 2'd1);
    else if (!upd_taken && (ctr_nxt != 2'd0))
      ctr_nxt = 2'(ctr_nxt - 2'd1);
`else
    lk_taken = 1'b1;
`endif
  end

  // Flush FSM state and sweep pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: a flush (re)starts the sweep, which ends after the last set.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = FLUSH;
          ptr_d   = '0;
        end
      end
      FLUSH: begin
        if (flush) begin
          ptr_d = '0;
        end else begin
          ptr_d = ptr_q + INDEX_WIDTH'(1);
          if (ptr_q == INDEX_WIDTH'(NUM_SETS - 1))
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Array writes: sweep clear, lookup LRU touch, then the update (last write wins on LRU).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lru_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < 2; w++) begin
          valid_q[w][s] <= 1'b0;
          tag_q[w][s]   <= '0;
          tgt_q[w][s]   <= '0;
`ifdef BTB_BHT_EN
          ctr_q[w][s]   <= 2'b00;
`endif
        end
      end
    end else if (state_q == FLUSH) begin
      valid_q[0][ptr_q] <= 1'b0;
      valid_q[1][ptr_q] <= 1'b0;
      lru_q[ptr_q]      <= 1'b0;
    end else begin
      if (lk_hit)
        lru_q[lk_idx] <= ~lk_way;
      if (up_en) begin
        if (up_hit) begin
`ifdef BTB_BHT_EN
          tgt_q[up_way][up_idx] <= upd_target;
          ctr_q[up_way][up_idx] <= ctr_nxt;
          lru_q[up_idx]         <= ~up_way;
`else
          if (upd_taken) begin
            tgt_q[up_way][up_idx] <= upd_target;
            lru_q[up_idx]         <= ~up_way;
          end else begin
            valid_q[up_way][up_idx] <= 1'b0;
          end
`endif
        end else if (upd_taken) begin
          valid_q[victim][up_idx] <= 1'b1;
          tag_q[victim][up_idx]   <= up_tag;
          tgt_q[victim][up_idx]   <= upd_target;
`ifdef BTB_BHT_EN
          ctr_q[victim][up_idx]   <= 2'b10;
`endif
          lru_q[up_idx]           <= ~victim;
        end
      end
    end
  end

  // Registered prediction outputs from the pre-update array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else begin
      pred_valid  <= lookup_valid;
      pred_hit    <= lk_hit;
      pred_taken  <= lk_hit && lk_taken;
      pred_target <= lk_hit ? tgt_q[lk_way][lk_idx] : '0;
    end
  end

endmodule

// File: tb/tb_btb_2way_assoc.sv
// Scoreboard bench for btb_2way_assoc: expected predictions are queued at lookup time
// and compared when pred_valid appears one cycle later.
module tb_btb_2way_assoc;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        busy;
  logic        lookup_valid = 1'b0;
  logic [9:0]  lookup_pc = '0;
  logic        pred_valid, pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [9:0]  upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;

  int checks = 0;
  int errors = 0;
  logic [33:0] sb[$];
  localparam logic [33:0] MISS = '0;

  btb_2way_assoc dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target)
  );

  always #5 clk = ~clk;

  // Overall time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [33:0] hitv(input logic taken, input logic [31:0] tgt);
    return {1'b1, taken, tgt};
  endfunction

  // One clock cycle of stimulus; outputs sampled 1 time unit after the edge.
  task automatic cyc(input logic lv, input logic [9:0] lpc, input logic uv, input logic [9:0] upc,
                     input logic ut, input logic [31:0] utgt, input logic fl, input logic [33:0] exp);
    lookup_valid = lv; lookup_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    flush = fl;
    if (lv) sb.push_back(exp);
    @(posedge clk); #1;
    lookup_valid = 1'b0; upd_valid = 1'b0; flush = 1'b0;
    check_eq("pred_valid", 64'(pred_valid), 64'(lv));
    if (pred_valid && sb.size() > 0) begin
      logic [33:0] e;
      e = sb.pop_front();
      check_eq("prediction", 64'({pred_hit, pred_taken, pred_target}), 64'(e));
    end
  endtask

  task automatic upd(input logic [9:0] pc, input logic t, input logic [31:0] tgt);
    cyc(1'b0, '0, 1'b1, pc, t, tgt, 1'b0, MISS);
  endtask

  task automatic look(input logic [9:0] pc, input logic [33:0] exp);
    cyc(1'b1, pc, 1'b0, '0, 1'b0, '0, 1'b0, exp);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    // Reset state
    @(posedge clk); #1;
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_pred_valid", 64'(pred_valid), 64'(0));
    check_eq("rst_pred", 64'({pred_hit, pred_taken, pred_target}), 64'(MISS));
    rst_n = 1'b1;

    // Allocate then look up
    upd(10'h040, 1'b1, 32'h0000_1000);
    look(10'h040, hitv(1'b1, 32'h1000));
    look(10'h044, MISS);

    // LRU eviction in set 0
    reset_dut();
    upd(10'h000, 1'b1, 32'hA0);
    upd(10'h020, 1'b1, 32'hB0);
    look(10'h000, hitv(1'b1, 32'hA0));
    upd(10'h040, 1'b1, 32'hC0);
    look(10'h020, MISS);
    look(10'h000, hitv(1'b1, 32'hA0));
    look(10'h040, hitv(1'b1, 32'hC0));
    upd(10'h200, 1'b0, 32'hD0);
    look(10'h200, MISS);

    // Same-cycle lookup and update sees the pre-update array
    cyc(1'b1, 10'h100, 1'b1, 10'h100, 1'b1, 32'h2000, 1'b0, MISS);
    look(10'h100, hitv(1'b1, 32'h2000));

    // Flush: update in the flush cycle and during the sweep are both dropped
    cyc(1'b0, '0, 1'b1, 10'h080, 1'b1, 32'h5000, 1'b1, MISS);
    check_eq("flush_busy", 64'(busy), 64'(1));
    cnt = busy ? 1 : 0;
    cyc(1'b1, 10'h100, 1'b1, 10'h040, 1'b1, 32'h3000, 1'b0, MISS);
    if (busy) cnt++;
    for (int i = 0; i < 20 && busy; i++) begin
      cyc(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, MISS);
      if (busy) cnt++;
    end
    check_eq("busy_cycles", 64'(cnt), 64'(8));
    look(10'h040, MISS);
    look(10'h080, MISS);
    look(10'h000, MISS);

    // Reset in the middle of a sweep
    upd(10'h000, 1'b1, 32'h11);
    upd(10'h104, 1'b1, 32'h22);
    cyc(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, MISS);
    cyc(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, MISS);
    cyc(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, MISS);
    check_eq("busy_before_rst", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check_eq("busy_in_rst", 64'(busy), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("busy_after_rst", 64'(busy), 64'(0));
    look(10'h000, MISS);
    look(10'h104, MISS);
    look(10'h040, MISS);

    // Not-taken update on a hit entry
    reset_dut();
    upd(10'h040, 1'b1, 32'h1000);
    upd(10'h040, 1'b0, 32'h1000);
`ifdef BTB_BHT_EN
    look(10'h040, {1'b1, 1'b0, 32'h1000});
    upd(10'h040, 1'b1, 32'h1000);
    upd(10'h040, 1'b1, 32'h1000);
    look(10'h040, hitv(1'b1, 32'h1000));
`else
    look(10'h040, MISS);
    upd(10'h040, 1'b1, 32'h1234);
    look(10'h040, hitv(1'b1, 32'h1234));
`endif
    cyc(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, MISS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
